// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity, SB_TICK-tick stop.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state between DATA and STOP).
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_empty,
  input  logic [DBIT-1:0] tx_data,
  output logic            tx_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic [2:0]      dbg_state_o
);

  // Tick counter is 4 bits; it only widens when a 1.5/2-stop setting needs more range.
  localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

  state_t          state_q, state_d;
  logic [TW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // tx_d always carries the line level of the state being entered, so tx is a pure flop output.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    tx_d         = tx_q;
    tx_rd        = 1'b0;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!tx_empty && reset) begin
          tx_rd   = 1'b1;
          b_d     = tx_data;
          s_d     = '0;
          tx_d    = 1'b0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == TW'(15)) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == TW'(15)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = par_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              n_d  = n_q + NW'(1);
              tx_d = b_q[1];
            end
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == TW'(15)) begin
            state_d = STOP;
            s_d     = '0;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == TW'(SB_TICK - 1)) begin
            state_d      = IDLE;
            tx_done_tick = 1'b1;
            tx_d         = 1'b1;
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx          = tx_q;
  assign tx_busy     = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter SB_TICK, default 16, s_tick count for stop bit (16 = 1 stop, 24 = 1.5 stops, 32 = 2 stops).
REQ-003 SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_tick  input  1  one-clk enable pulse at 16x baud rate.
REQ-006 SHALL have port tx_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port tx_data  input  DBIT  upstream FIFO read data, valid whenever tx_empty=0.
REQ-008 SHALL have port tx_rd  output  1  FIFO pop strobe, one clk wide.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port tx_busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port tx_done_tick  output  1  one-clk pulse at end of stop bit.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, with a 4-bit tick counter and a bit counter of width ceil(log2(DBIT)).
REQ-013 In IDLE with tx_empty=0, SHALL latch tx_data into a shift register, assert tx_rd for that single clk, clear the tick counter and enter START on the same edge.
REQ-014 SHALL never assert tx_rd when tx_empty=1 or outside IDLE.
REQ-015 Tick counter SHALL advance only on clks with s_tick=1; without s_tick, state, counters and tx SHALL hold.
REQ-016 START SHALL drive tx=0 for 16 s_ticks, then enter DATA with the tick and bit counters cleared.
REQ-017 DATA SHALL drive tx=shift_reg[0], LSB first; after 16 s_ticks it SHALL shift right and increment the bit counter; after bit DBIT-1 it SHALL enter PARITY (macro) or STOP.
REQ-018 STOP SHALL drive tx=1 for SB_TICK s_ticks, then pulse tx_done_tick for one clk and return to IDLE.
REQ-019 Back-to-back frames: after STOP, IDLE SHALL last exactly one clk before the next tx_rd when tx_empty=0.
REQ-020 tx SHALL be driven from a register, glitch-free.
REQ-021 Changes on tx_data or tx_empty outside IDLE SHALL NOT affect the frame in progress.

Reset
REQ-022 On reset=0, regardless of clk, SHALL force state=IDLE, tx=1, tx_rd=0, tx_busy=0, tx_done_tick=0, and clear all counters and the shift register.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no tx_done_tick; the popped word is lost.
REQ-024 After reset release, SHALL start a frame no earlier than the first rising edge with reset=1.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: SHALL include the PARITY state between DATA and STOP, driving tx=XOR of the DBIT data bits (even parity) for 16 s_ticks.
REQ-026 Macro UART_TX_PARITY_EN undefined: SHALL omit the PARITY state and its logic entirely; DATA goes directly to STOP.

Verification
REQ-027 Reset held low, then released with tx_empty=1 -> tx=1, tx_rd=0, tx_busy=0 indefinitely.
REQ-028 DBIT=8, tx_data=8'hA5, tx_empty falls -> one tx_rd pulse; tx low 16 ticks, then bits 1,0,1,0,0,1,0,1, high 16 ticks; tx_done_tick=1 after 160 ticks (no parity).
REQ-029 Two words 8'h00 and 8'hFF queued -> two tx_rd pulses; second start bit begins 2 clks after first tx_done_tick; no extra pop.
REQ-030 reset=0 at tick 70 of a frame -> tx=1 same cycle, no tx_done_tick; after release with tx_empty=0, a new full frame is sent.
REQ-031 UART_TX_PARITY_EN defined, tx_data=8'h07 -> parity bit 1, done after 176 ticks; tx_data=8'h03 -> parity bit 0.
REQ-032 s_tick held low for 100 clks mid-DATA -> tx and counters frozen; frame completes correctly once s_tick resumes.
